writeback_unit: RTL and testbench

//   Drives the single write port of the 32x32 register file. Merges ALU results

---
 rtl/writeback_unit_pkg.sv | 17 +
 rtl/writeback_unit_wb_fifo.sv | 49 ++++
 rtl/writeback_unit.sv | 92 +++++++++
 tb/tb_writeback_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared widths and constants for the writeback unit
package writeback_unit_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } ll_entry_t;

    localparam int ENTRY_W = $bits(ll_entry_t);

endpackage

// File: rtl/writeback_unit_wb_fifo.sv
// rtl/writeback_unit_wb_fifo.sv - small synchronous FIFO holding buffered long-latency results
module writeback_unit_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    // Pointer update; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    // Entry storage; contents are meaningless while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register file write port arbiter with LL result buffer and pending scoreboard
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int LL_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ll_issue,
    input  logic [ADDR_W-1:0]   ll_issue_reg,
    input  logic                ll_valid,
    output logic                ll_ready,
    input  logic [ADDR_W-1:0]   ll_reg,
    input  logic [DATA_W-1:0]   ll_data,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   WriteReg,
    output logic [DATA_W-1:0]   WriteData,
    output logic [NUM_REGS-1:0] pending
);

    logic      full;
    logic      empty;
    logic      alu_write;
    logic      push;
    logic      pop;
    ll_entry_t head;
    ll_entry_t din;

    logic [NUM_REGS-1:0] pending_next;

    // ALU always wins the port; writes to $zero are treated as absent.
    assign alu_write = alu_valid && (alu_reg != REG_ZERO);
    assign ll_ready  = !full && !rst;
    assign push      = ll_valid && ll_ready && (ll_reg != REG_ZERO);
    assign pop       = !alu_write && !empty && !rst;

    assign din.dest  = ll_reg;
    assign din.data  = ll_data;

    writeback_unit_wb_fifo #(
        .DEPTH (LL_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Scoreboard next state: clear on pop first so a same-cycle issue set wins.
    always_comb begin
        pending_next = pending;
        if (pop) begin
            pending_next[head.dest] = 1'b0;
        end
        if (ll_issue && (ll_issue_reg != REG_ZERO)) begin
            pending_next[ll_issue_reg] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Registered write port and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            pending   <= '0;
        end else begin
            pending <= pending_next;
            if (alu_write) begin
                RegWrite  <= 1'b1;
                WriteReg  <= alu_reg;
                WriteData <= alu_data;
            end else if (pop) begin
                RegWrite  <= 1'b1;
                WriteReg  <= head.dest;
                WriteData <= head.data;
            end else begin
                RegWrite  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        ll_issue;
    logic [4:0]  ll_issue_reg;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_reg;
    logic [31:0] ll_data;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    writeback_unit dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .ll_issue     (ll_issue),
        .ll_issue_reg (ll_issue_reg),
        .ll_valid     (ll_valid),
        .ll_ready     (ll_ready),
        .ll_reg       (ll_reg),
        .ll_data      (ll_data),
        .RegWrite     (RegWrite),
        .WriteReg     (WriteReg),
        .WriteData    (WriteData),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        ll_issue = 0; ll_issue_reg = 0;
        ll_valid = 0; ll_reg = 0; ll_data = 0;
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] d);
        alu_valid = 1; alu_reg = r; alu_data = d;
    endtask

    task automatic ll(input logic [4:0] r, input logic [31:0] d);
        ll_valid = 1; ll_reg = r; ll_data = d;
    endtask

    initial begin
        // Reset with every input active
        #1;
        rst = 1;
        alu(5, 32'h1234); ll(4, 32'h55);
        ll_issue = 1; ll_issue_reg = 3;
        tick(); tick();
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_ll_ready", 32'(ll_ready), 32'd0);
        chk("rst_writereg", 32'(WriteReg), 32'd0);
        chk("rst_writedata", WriteData, 32'd0);
        rst = 0;
        idle();
        #1;
        chk("post_rst_ll_ready", 32'(ll_ready), 32'd1);

        // ALU only
        alu(5, 32'hDEADBEEF);
        tick();
        chk("alu_regwrite", 32'(RegWrite), 32'd1);
        chk("alu_writereg", 32'(WriteReg), 32'd5);
        chk("alu_writedata", WriteData, 32'hDEADBEEF);
        idle();
        tick();
        chk("idle_regwrite", 32'(RegWrite), 32'd0);
        chk("idle_hold_reg", 32'(WriteReg), 32'd5);
        chk("idle_hold_data", WriteData, 32'hDEADBEEF);

        // Conflict: LL r7 accepted at N, ALU owns N+1..N+3, LL lands after N+4
        ll(7, 32'h11);
        tick();
        chk("conf_n_regwrite", 32'(RegWrite), 32'd0);
        idle();
        alu(3, 32'h31);
        tick();
        chk("conf_n1_reg", 32'(WriteReg), 32'd3);
        alu(3, 32'h32);
        tick();
        chk("conf_n2_reg", 32'(WriteReg), 32'd3);
        alu(3, 32'h33);
        tick();
        chk("conf_n3_reg", 32'(WriteReg), 32'd3);
        chk("conf_n3_data", WriteData, 32'h33);
        idle();
        tick();
        chk("conf_n4_regwrite", 32'(RegWrite), 32'd1);
        chk("conf_n4_reg", 32'(WriteReg), 32'd7);
        chk("conf_n4_data", WriteData, 32'h11);
        tick();
        chk("conf_drained", 32'(RegWrite), 32'd0);

        // Full buffer while ALU is busy
        alu(3, 32'hA0); ll(8, 32'h80);
        tick();
        chk("full_one_ready", 32'(ll_ready), 32'd1);
        ll(9, 32'h90);
        tick();
        ll_valid = 0;
        #1;
        chk("full_ll_ready", 32'(ll_ready), 32'd0);
        chk("full_alu_reg", 32'(WriteReg), 32'd3);
        idle();
        tick();
        chk("full_pop8_reg", 32'(WriteReg), 32'd8);
        chk("full_pop8_data", WriteData, 32'h80);
        chk("full_ready_back", 32'(ll_ready), 32'd1);
        tick();
        chk("full_pop9_reg", 32'(WriteReg), 32'd9);
        chk("full_pop9_data", WriteData, 32'h90);
        tick();
        chk("full_empty_regwrite", 32'(RegWrite), 32'd0);

        // $zero handling
        alu(3, 32'hB0); ll(4, 32'h44);
        tick();
        idle();
        alu(0, 32'hFFFF);
        tick();
        chk("zero_alu_regwrite", 32'(RegWrite), 32'd1);
        chk("zero_alu_reg", 32'(WriteReg), 32'd4);
        chk("zero_alu_data", WriteData, 32'h44);
        idle();
        ll(0, 32'h99);
        tick();
        chk("zero_ll_regwrite_a", 32'(RegWrite), 32'd0);
        idle();
        tick();
        chk("zero_ll_regwrite_b", 32'(RegWrite), 32'd0);
        ll_issue = 1; ll_issue_reg = 0;
        tick();
        chk("zero_issue_pending", pending, 32'd0);

        // Scoreboard: set, set-wins-over-clear, then plain clear
        idle();
        ll_issue = 1; ll_issue_reg = 12;
        tick();
        chk("sb_set", pending, 32'h0000_1000);
        idle();
        alu(3, 32'hC0); ll(12, 32'hC);
        tick();
        chk("sb_hold_while_buffered", pending, 32'h0000_1000);
        idle();
        ll_issue = 1; ll_issue_reg = 12;
        tick();
        chk("sb_pop_reg", 32'(WriteReg), 32'd12);
        chk("sb_set_wins", pending, 32'h0000_1000);
        idle();
        alu(3, 32'hC1); ll(12, 32'hD);
        tick();
        idle();
        tick();
        chk("sb_clear_reg", 32'(WriteReg), 32'd12);
        chk("sb_clear", pending, 32'd0);

        // Reset mid-operation discards buffer and pending
        ll_issue = 1; ll_issue_reg = 20;
        alu(3, 32'hE0); ll(20, 32'h20);
        tick();
        chk("mid_pending_set", pending, 32'h0010_0000);
        idle();
        rst = 1;
        tick();
        chk("mid_rst_pending", pending, 32'd0);
        chk("mid_rst_regwrite", 32'(RegWrite), 32'd0);
        rst = 0;
        tick();
        chk("mid_rst_discard", 32'(RegWrite), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
